// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the MEM stage with bounded fetch starvation
// Ports: clk, rst (async, active-high); fetch side if_req/if_addr -> if_rdata/if_ready;
// MEM side mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ready; stall to pipeline;
// shared port bus_req/bus_we/bus_addr/bus_wdata -> memory, bus_rdata/bus_ack <- memory.
module mem_port_arbiter #(
  parameter int unsigned MAX_IF_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, DONE} state_t;
  localparam logic [3:0] MAX_WAIT = 4'(MAX_IF_WAIT);
  state_t      r_state, w_next;
  logic [3:0]  r_wait_cnt, w_wait_next;
  logic        r_gnt_if;
  logic        r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata, r_if_rdata, r_mem_rdata;
  logic        w_pick_mem, w_pick_if, w_grant;
  // MEM wins unless fetch has already waited through MAX_WAIT MEM grants
  assign w_pick_mem = mem_req & (~if_req | (r_wait_cnt < MAX_WAIT));
  assign w_pick_if  = if_req & ~w_pick_mem;
  assign w_grant    = (r_state == IDLE) & (w_pick_mem | w_pick_if);
  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait_cnt;
    case (r_state)
      IDLE: begin
        w_next      = w_pick_mem ? GNT_MEM : w_pick_if ? GNT_IF : IDLE;
        w_wait_next = (~if_req | w_pick_if) ? 4'd0 :
                      (w_pick_mem & (r_wait_cnt < MAX_WAIT)) ? r_wait_cnt + 4'd1 : r_wait_cnt;
      end
      GNT_IF, GNT_MEM: w_next = bus_ack ? DONE : r_state;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_gnt_if    <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_grant) begin
        r_gnt_if    <= w_pick_if;
        r_bus_addr  <= w_pick_mem ? mem_addr : if_addr;
        r_bus_we    <= w_pick_mem & mem_we;
        r_bus_wdata <= w_pick_mem ? mem_wdata : 32'd0;
      end
      if ((r_state == GNT_IF) && bus_ack) r_if_rdata <= bus_rdata;
      if ((r_state == GNT_MEM) && bus_ack && !r_bus_we) r_mem_rdata <= bus_rdata;
    end
  end
  assign bus_req   = (r_state == GNT_IF) | (r_state == GNT_MEM);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_ready  = (r_state == DONE) & r_gnt_if;
  assign mem_ready = (r_state == DONE) & ~r_gnt_if;
  assign stall     = (if_req & ~if_ready) | (mem_req & ~mem_ready);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transaction-level checks of mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAXW = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_ready, mem_ready, stall, bus_req, bus_we;
  int          checks = 0;
  int          failures = 0;
  int          streak;
  logic [31:0] exp_if_rdata, exp_mem_rdata, saved_addr;
  logic [9:0]  pat;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MAX_IF_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // Fetch is granted when it is alone, or once it has watched MAXW MEM grants go by
  function automatic logic pick_if(input logic ip, input logic mp, input int s);
    return ip && (!mp || s >= MAXW);
  endfunction
  // Called at the falling edge of an IDLE cycle with requests already driven;
  // acts as the memory with ack after d waiting cycles, then checks the ready pulse.
  task automatic serve(input logic gif, input int d, input logic [31:0] rd,
                       input logic keep, input logic ack_in_done);
    logic [31:0] a, w, o_if_addr, o_mem_addr, o_mem_wdata;
    logic        we;
    a  = gif ? if_addr : mem_addr;
    we = gif ? 1'b0 : mem_we;
    w  = gif ? 32'd0 : mem_wdata;
    if (gif) streak = 0;
    else if (if_req) streak = (streak < MAXW) ? streak + 1 : MAXW;
    else streak = 0;
    o_if_addr = if_addr; o_mem_addr = mem_addr; o_mem_wdata = mem_wdata;
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      chk1("bus_req", bus_req, 1'b1);
      chk("bus_addr", bus_addr, a);
      chk1("bus_we", bus_we, we);
      chk("bus_wdata", bus_wdata, w);
      chk1("if_ready_early", if_ready, 1'b0);
      chk1("mem_ready_early", mem_ready, 1'b0);
      chk1("stall_busy", stall, 1'b1);
      if (k == d) begin
        if_addr = o_if_addr; mem_addr = o_mem_addr; mem_wdata = o_mem_wdata;
        bus_ack = 1'b1; bus_rdata = rd;
      end else begin
        if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
      end
    end
    @(negedge clk);
    if (gif) exp_if_rdata = rd;
    else if (!we) exp_mem_rdata = rd;
    chk1("if_ready", if_ready, gif);
    chk1("mem_ready", mem_ready, !gif);
    chk1("bus_req_done", bus_req, 1'b0);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("mem_rdata", mem_rdata, exp_mem_rdata);
    chk1("stall_done", stall, gif ? mem_req : if_req);
    bus_ack = ack_in_done; bus_rdata = $urandom;
    if (!keep) begin
      if (gif) if_req = 1'b0;
      else mem_req = 1'b0;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("if_ready_once", if_ready, 1'b0);
    chk1("mem_ready_once", mem_ready, 1'b0);
    chk1("bus_req_idle", bus_req, 1'b0);
    chk("if_rdata_hold", if_rdata, exp_if_rdata);
    chk("mem_rdata_hold", mem_rdata, exp_mem_rdata);
  endtask
  initial begin
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
    streak = 0; exp_if_rdata = '0; exp_mem_rdata = '0;
    #12;
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk1("rst_stall", stall, 1'b0);
    // fetch only, arbitrated at the first edge after reset falls, minimum latency
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; rst = 1'b0;
    serve(1'b1, 0, 32'h00500093, 1'b0, 1'b0);
    // store with a 4-cycle ack delay: mem_rdata untouched
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
    serve(1'b0, 4, 32'h12345678, 1'b0, 1'b0);
    // load, with an ack left high in DONE that must be ignored
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2004;
    serve(1'b0, 2, 32'hCAFEF00D, 1'b0, 1'b1);
    // spurious ack in IDLE
    saved_addr = bus_addr;
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("spur_if_ready", if_ready, 1'b0);
    chk1("spur_mem_ready", mem_ready, 1'b0);
    chk1("spur_bus_req", bus_req, 1'b0);
    chk("spur_bus_addr", bus_addr, saved_addr);
    chk("spur_if_rdata", if_rdata, exp_if_rdata);
    chk("spur_mem_rdata", mem_rdata, exp_mem_rdata);
    chk1("spur_stall", stall, 1'b0);
    // both requesters held: MEM x4 then IF, twice
    pat = 10'b10000_10000;
    if_req = 1'b1; if_addr = 32'h400; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000;
    for (int i = 0; i < 10; i++) serve(pat[i], $urandom_range(0, 2), $urandom, 1'b1, 1'b0);
    if_req = 1'b0; mem_req = 1'b0; streak = 0;
    @(negedge clk);
    // reset in the middle of a MEM access
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000;
    @(negedge clk);
    chk1("pre_rst_bus_req", bus_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("mid_rst_bus_req", bus_req, 1'b0);
    chk("mid_rst_bus_addr", bus_addr, 32'd0);
    chk1("mid_rst_mem_ready", mem_ready, 1'b0);
    chk("mid_rst_mem_rdata", mem_rdata, 32'd0);
    chk("mid_rst_if_rdata", if_rdata, 32'd0);
    exp_if_rdata = '0; exp_mem_rdata = '0; streak = 0; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h77777777;
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("late_ack_mem_ready", mem_ready, 1'b0);
    chk1("late_ack_if_ready", if_ready, 1'b0);
    chk("late_ack_mem_rdata", mem_rdata, 32'd0);
    chk1("late_ack_bus_req", bus_req, 1'b0);
    @(negedge clk);
    chk1("late_ack_mem_ready2", mem_ready, 1'b0);
    // random traffic against the transaction-level fairness model
    for (int r = 0; r < 150; r++) begin
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!mem_req && $urandom_range(0, 2) != 0) begin
        mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1)); mem_addr = $urandom; mem_wdata = $urandom;
      end
      if (!if_req && !mem_req) begin
        streak = 0;
        @(negedge clk);
        chk1("rand_idle_bus_req", bus_req, 1'b0);
      end else begin
        serve(pick_if(if_req, mem_req, streak), $urandom_range(0, 3), $urandom, 1'b0,
              1'($urandom_range(0, 1)));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_IF_WAIT, default 4, sets the number of consecutive MEM-stage grants allowed while fetch waits; legal range 1-15.
REQ-002 Port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port if_req, input, 1, fetch requests a read; held until if_ready is seen.
REQ-005 Port if_addr, input, 32, fetch address.
REQ-006 Port if_rdata, output, 32, registered instruction word.
REQ-007 Port if_ready, output, 1, one-cycle pulse marking fetch completion.
REQ-008 Port mem_req, input, 1, MEM stage requests an access; held until mem_ready is seen.
REQ-009 Port mem_we, input, 1, 1 = store, 0 = load.
REQ-010 Port mem_addr, input, 32, load/store address.
REQ-011 Port mem_wdata, input, 32, store data.
REQ-012 Port mem_rdata, output, 32, registered load data.
REQ-013 Port mem_ready, output, 1, one-cycle pulse marking MEM completion.
REQ-014 Port stall, output, 1, combinational pipeline stall.
REQ-015 Port bus_req, output, 1, shared memory port request.
REQ-016 Port bus_we, output, 1, shared port write enable.
REQ-017 Port bus_addr, output, 32, shared port address.
REQ-018 Port bus_wdata, output, 32, shared port write data.
REQ-019 Port bus_rdata, input, 32, shared port read data; valid when bus_ack = 1.
REQ-020 Port bus_ack, input, 1, shared port completion; may arrive 1 or more cycles after bus_req rises.

Function
REQ-021 The FSM SHALL have four states: IDLE, GNT_IF, GNT_MEM and DONE.
REQ-022 In IDLE with mem_req=1 and (if_req=0 or wait_cnt<MAX_IF_WAIT), the next state SHALL be GNT_MEM.
REQ-023 In IDLE with if_req=1 and (mem_req=0 or wait_cnt==MAX_IF_WAIT), the next state SHALL be GNT_IF.
REQ-024 On entry to a GNT state, bus_addr, bus_we and bus_wdata SHALL be latched from the granted requester (for IF, bus_we=0 and bus_wdata=0), and bus_req SHALL be 1.
REQ-025 The latched bus_addr, bus_we and bus_wdata SHALL remain stable until bus_ack, independent of requester inputs.
REQ-026 In GNT_x with bus_ack=1, the block SHALL move to DONE and drop bus_req in the next cycle.
REQ-027 On that same bus_ack, a read SHALL capture bus_rdata into if_rdata or mem_rdata; a store SHALL leave mem_rdata unchanged.
REQ-028 In DONE, the granted requester's ready SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-029 Requests seen in DONE SHALL be ignored.
REQ-030 Minimum latency is 3 cycles: request seen in IDLE at edge N, bus_req high in cycle N+1, bus_ack in N+1, ready high in cycle N+2.
REQ-031 bus_ack in IDLE or DONE SHALL be ignored, with no state or data change.
REQ-032 wait_cnt (4 bits) SHALL increment, saturating at MAX_IF_WAIT, on each GNT_MEM decision made while if_req=1.
REQ-033 wait_cnt SHALL clear on every GNT_IF decision.
REQ-034 wait_cnt SHALL clear on any IDLE cycle with if_req=0.
REQ-035 stall SHALL equal (if_req & ~if_ready) | (mem_req & ~mem_ready).

Reset
REQ-036 When rst=1, immediately and regardless of clk, the state SHALL be IDLE and wait_cnt 0.
REQ-037 When rst=1, bus_req, bus_we, if_ready and mem_ready SHALL be 0.
REQ-038 When rst=1, bus_addr, bus_wdata, if_rdata and mem_rdata SHALL be 0.
REQ-039 Reset during GNT_x SHALL abandon the access with no ready pulse.
REQ-040 A bus_ack after reset SHALL be ignored per REQ-031.
REQ-041 After rst falls, the first arbitration SHALL occur at the first rising edge.

Verification
REQ-042 Fetch only: if_req=1, if_addr=0x100; bus_ack one cycle after bus_req with bus_rdata=0x00500093 -> bus_addr=0x100, bus_we=0, if_rdata=0x00500093, if_ready pulses once, 3-cycle latency.
REQ-043 Store: mem_req=1, mem_we=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF; bus_ack delayed 4 cycles -> bus signals stable throughout, mem_ready one pulse, mem_rdata unchanged, stall=1 until mem_ready.
REQ-044 Simultaneous requests: if_req=1 and mem_req=1 held continuously, MAX_IF_WAIT=4 -> grant order MEM,MEM,MEM,MEM,IF, then the pattern repeats.
REQ-045 Reset mid-access: assert rst while in GNT_MEM before bus_ack -> bus_req falls asynchronously, no mem_ready, a later bus_ack is ignored.
REQ-046 Spurious ack: bus_ack=1 in IDLE with no requests -> no ready pulses, all outputs unchanged.
